// File: rtl/trax_neighbour_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : trax_neighbour_fetch_if
// Brief    : Request, board-RAM, checker and result signals of the TRAX
//            neighbour fetch stage. The master modport is the fetch stage;
//            the slave modport is its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface trax_neighbour_fetch_if #(
    parameter int ROW_W = 3,
    parameter int COL_W = 3
);
    logic                     req;
    logic [ROW_W-1:0]         req_row;
    logic [COL_W-1:0]         req_col;
    logic                     busy;
    logic                     mem_rd;
    logic [ROW_W+COL_W-1:0]   mem_addr;
    logic [11:0]              mem_rdata;
    logic [2:0]               up_tile;
    logic [2:0]               down_tile;
    logic [2:0]               right_tile;
    logic [2:0]               left_tile;
    logic                     chk_start;
    logic                     chk_end;
    logic [5:0]               chk_type;
    logic                     result_valid;
    logic [5:0]               result_type;
    logic                     result_err;
    logic                     no_nbr;

    modport master (
        input  req, req_row, req_col, mem_rdata, chk_end, chk_type,
        output busy, mem_rd, mem_addr, up_tile, down_tile, right_tile,
               left_tile, chk_start, result_valid, result_type, result_err,
               no_nbr
    );

    modport slave (
        output req, req_row, req_col, mem_rdata, chk_end, chk_type,
        input  busy, mem_rd, mem_addr, up_tile, down_tile, right_tile,
               left_tile, chk_start, result_valid, result_type, result_err,
               no_nbr
    );
endinterface
`default_nettype wire

// File: rtl/trax_neighbour_fetch.sv
`default_nettype none
// ============================================================================
// Module   : trax_neighbour_fetch
// Brief    : Reads the four neighbours of a board cell from synchronous RAM,
//            extracts their facing edge colours, runs the tile checker and
//            returns the selected tile type with a timeout guard.
// Revision : 1.0 - initial release
// ============================================================================
module trax_neighbour_fetch #(
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trax_neighbour_fetch_if.master bus
);
    localparam int                 c_ADDR_W   = ROW_W + COL_W;
    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [ROW_W-1:0]   c_ROW_MAX  = {ROW_W{1'b1}};
    localparam logic [COL_W-1:0]   c_COL_MAX  = {COL_W{1'b1}};

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_DRAIN = 3'd2;
    localparam logic [2:0] c_ST_START = 3'd3;
    localparam logic [2:0] c_ST_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [1:0]          r_idx;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic [2:0]          r_up, r_down, r_right, r_left;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [5:0]          r_res_type;
    logic                r_res_err;
    logic                r_no_nbr;

    logic [ROW_W-1:0]    w_row_m1, w_row_p1;
    logic [COL_W-1:0]    w_col_m1, w_col_p1;
    logic [3:0]          w_oob;        // slot order: up, down, right, left
    logic                w_cap_en;
    logic [1:0]          w_cap_slot;
    logic [2:0]          w_cap_val;
    logic                w_all_empty;
    logic                w_timeout;
    logic                w_busy, w_mem_rd, w_chk_start, w_result_valid;
    logic [c_ADDR_W-1:0] w_mem_addr;

    assign w_row_m1 = r_row - ROW_W'(1);
    assign w_row_p1 = r_row + ROW_W'(1);
    assign w_col_m1 = r_col - COL_W'(1);
    assign w_col_p1 = r_col + COL_W'(1);

    assign w_oob[0] = (r_row == '0);
    assign w_oob[1] = (r_row == c_ROW_MAX);
    assign w_oob[2] = (r_col == c_COL_MAX);
    assign w_oob[3] = (r_col == '0);

    // RAM data lags the read slot by one cycle; DRAIN catches the last slot
    assign w_cap_en   = ((r_state == c_ST_FETCH) && (r_idx != 2'd0)) || (r_state == c_ST_DRAIN);
    assign w_cap_slot = (r_state == c_ST_DRAIN) ? 2'd3 : (r_idx - 2'd1);

    // Select the edge of the neighbour that faces the target cell
    always_comb begin
        w_cap_val = 3'b000;
        if (!w_oob[w_cap_slot]) begin
            case (w_cap_slot)
                2'd0:    w_cap_val = bus.mem_rdata[5:3];
                2'd1:    w_cap_val = bus.mem_rdata[11:9];
                2'd2:    w_cap_val = bus.mem_rdata[2:0];
                default: w_cap_val = bus.mem_rdata[8:6];
            endcase
        end
    end

    // Left field is still being captured in DRAIN, so use its incoming value
    assign w_all_empty = (r_up == 3'b000) && (r_down == 3'b000) &&
                         (r_right == 3'b000) && (w_cap_val == 3'b000);
    assign w_timeout   = (r_cnt == c_CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.req) w_next = c_ST_FETCH;
            c_ST_FETCH: if (r_idx == 2'd3) w_next = c_ST_DRAIN;
            c_ST_DRAIN: w_next = w_all_empty ? c_ST_DONE : c_ST_START;
            c_ST_START: w_next = c_ST_WAIT;
            c_ST_WAIT:  if (bus.chk_end || w_timeout) w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // Per-state outputs: RAM read slots, checker start, completion pulse
    always_comb begin
        w_busy         = (r_state != c_ST_IDLE);
        w_mem_rd       = 1'b0;
        w_mem_addr     = '0;
        w_chk_start    = (r_state == c_ST_START);
        w_result_valid = (r_state == c_ST_DONE);
        if (r_state == c_ST_FETCH && !w_oob[r_idx]) begin
            w_mem_rd = 1'b1;
            case (r_idx)
                2'd0:    w_mem_addr = {w_row_m1, r_col};
                2'd1:    w_mem_addr = {w_row_p1, r_col};
                2'd2:    w_mem_addr = {r_row, w_col_p1};
                default: w_mem_addr = {r_row, w_col_m1};
            endcase
        end
    end

    // Datapath: request latch, neighbour capture, timeout counter, results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_up       <= '0;
            r_down     <= '0;
            r_right    <= '0;
            r_left     <= '0;
            r_cnt      <= '0;
            r_res_type <= '0;
            r_res_err  <= 1'b0;
            r_no_nbr   <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE && bus.req) begin
                r_row      <= bus.req_row;
                r_col      <= bus.req_col;
                r_idx      <= 2'd0;
                r_res_type <= '0;
                r_res_err  <= 1'b0;
                r_no_nbr   <= 1'b0;
            end
            if (r_state == c_ST_FETCH) r_idx <= r_idx + 2'd1;
            if (w_cap_en) begin
                case (w_cap_slot)
                    2'd0:    r_up    <= w_cap_val;
                    2'd1:    r_down  <= w_cap_val;
                    2'd2:    r_right <= w_cap_val;
                    default: r_left  <= w_cap_val;
                endcase
            end
            if (r_state == c_ST_DRAIN && w_all_empty) begin
                r_no_nbr   <= 1'b1;
                r_res_type <= '0;
                r_res_err  <= 1'b0;
            end
            if (r_state == c_ST_START) r_cnt <= '0;
            if (r_state == c_ST_WAIT) begin
                if (bus.chk_end) begin
                    r_res_type <= bus.chk_type;
                    r_res_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_res_type <= '0;
                    r_res_err  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.mem_rd       = w_mem_rd;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.chk_start    = w_chk_start;
    assign bus.result_valid = w_result_valid;
    assign bus.up_tile      = r_up;
    assign bus.down_tile    = r_down;
    assign bus.right_tile   = r_right;
    assign bus.left_tile    = r_left;
    assign bus.result_type  = r_res_type;
    assign bus.result_err   = r_res_err;
    assign bus.no_nbr       = r_no_nbr;
endmodule
`default_nettype wire
